stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
- Registered N-to-1 stream multiplexer with N = 2**SEL_WIDTH channels of WIDTH bits each. It is the sequential, handshaked successor of the library combinational multiplexer.
- Per-channel valid/ready handshakes, one output register stage, and two selection modes: fixed select or round-robin arbitration.
- Used wherever several producers (bus masters, debug/UART sources) share one downstream consumer.

Parameters:
- SEL_WIDTH, 2, select width; channel count N = 2**SEL_WIDTH.
- WIDTH, 8, data bits per channel.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i  input  N*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- i_valid  input  N  per-channel valid.
- o_ready_in  output  N  per-channel ready; channel k transfers when i_valid[k] & o_ready_in[k].
- i_sel  input  SEL_WIDTH  channel index used in fixed mode.
- i_mode  input  1  0 = fixed select, 1 = round-robin.
- o  output  WIDTH  registered output data.
- o_valid  output  1  output register holds data.
- i_ready  input  1  downstream ready; output transfers when o_valid & i_ready.
- o_ch  output  SEL_WIDTH  source channel of the current o.

Behaviour:
- Reset (asynchronous, active-high): o=0, o_valid=0, o_ch=0, round-robin pointer ptr=0. All o_ready_in=0 while reset is high.
- Load enable: load = ~o_valid | i_ready. This is a combinational function of the register state and i_ready.
- Selection, combinational, evaluated each cycle:
  - Fixed mode: candidate = i_sel; a grant occurs only if i_valid[i_sel]=1.
  - Round-robin mode: the candidate is the first k with i_valid[k]=1, searching ptr, ptr+1, ... modulo N (wraps N-1 -> 0). There is no grant if all i_valid=0.
- o_ready_in[k] = load & grant & (k == candidate). At most one bit is high per cycle; o_ready_in must not depend on i_valid of the other channels except through the arbiter.
- On a clock edge with load & grant: o <= selected channel data, o_ch <= candidate, o_valid <= 1.
- On a clock edge with load & ~grant: o_valid <= 0. o and o_ch hold their previous values.
- ~load (o_valid=1, i_ready=0): o, o_ch and o_valid hold; no channel is acknowledged. This is backpressure.
- Latency: 1 cycle from input transfer to o_valid. Full throughput: 1 transfer per cycle when i_ready is held high.
- Pointer update: on each round-robin-mode grant, ptr <= candidate+1 (mod N). Fixed-mode grants do not change ptr.
- Mode switching: i_mode takes effect in the same cycle. It never disturbs a word already held in the output register.
- Simultaneous output accept and new load in the same cycle is legal and required (pipeline refill).
- Reset asserted mid-transfer: the held word is discarded and o_valid falls immediately. No channel is acknowledged until the first edge after reset deasserts.
- i_sel out of range is impossible because its width exactly covers N.

Test Plan:
- Reset, then i_mode=0, i_sel=2, i_valid=4'b0100, i[ch2]=8'hA5, i_ready=1 -> o_ready_in=4'b0100 in cycle 0; o=8'hA5, o_valid=1, o_ch=2 after the next edge.
- Fixed mode, i_sel=1, i_valid=4'b1101 (ch1 idle) -> o_ready_in=0 and o_valid=0 after the edge; ptr unchanged.
- Round-robin, all four channels valid continuously, i_ready=1 -> o_ch sequence 0,1,2,3,0,... on consecutive cycles, one word per cycle, each o equal to that channel's data.
- Round-robin, i_valid=4'b1001 with ptr=1 -> ch3 granted first, then ch0 (wrap); ptr=1 after the ch0 grant.
- Backpressure: o_valid=1, o=8'h11, i_ready=0 for 3 cycles with ch1 valid -> o stays 8'h11, o_ready_in=0. On i_ready=1, ch1 data loads on the same edge that 8'h11 is accepted.
- Assert reset while o_valid=1 between edges -> o_valid=0, o=0, o_ch=0 immediately; the first grant after release starts at ch0 in round-robin mode.

Source files
------------

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: registered N-to-1 stream multiplexer, where N = 2**SEL_WIDTH.
// Each input channel has its own valid/ready handshake, and the design has one
// output register stage. A channel is chosen by fixed select (i_mode=0) or by
// round-robin arbitration (i_mode=1).
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   i           packed channel data; channel k is i[k*WIDTH +: WIDTH]
//   i_valid     per-channel valid
//   o_ready_in  per-channel ready; at most one bit is high
//   i_sel       channel index used in fixed mode
//   i_mode      0 = fixed select, 1 = round-robin
//   o           registered output data
//   o_valid     the output register holds a word
//   i_ready     downstream ready
//   o_ch        source channel of the current o
module stream_mux_arb #(
    parameter int SEL_WIDTH = 2,
    parameter int WIDTH     = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [(2**SEL_WIDTH)*WIDTH-1:0] i,
    input  logic [(2**SEL_WIDTH)-1:0]       i_valid,
    output logic [(2**SEL_WIDTH)-1:0]       o_ready_in,
    input  logic [SEL_WIDTH-1:0]            i_sel,
    input  logic                            i_mode,
    output logic [WIDTH-1:0]                o,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [SEL_WIDTH-1:0]            o_ch
);
    localparam int N = 2**SEL_WIDTH;

    logic [WIDTH-1:0]     data_r;
    logic                 valid_r;
    logic [SEL_WIDTH-1:0] ch_r;
    logic [SEL_WIDTH-1:0] ptr_r;

    logic [WIDTH-1:0]     ch_data_s [N];
    logic                 load_s;
    logic                 grant_s;
    logic [SEL_WIDTH-1:0] cand_s;
    logic [SEL_WIDTH-1:0] scan_idx_s;
    logic [SEL_WIDTH-1:0] next_ptr_s;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign ch_data_s[k] = i[k*WIDTH +: WIDTH];
    end

    // The output register may take a new word when it is empty or is draining this cycle.
    assign load_s     = ~valid_r | i_ready;
    assign next_ptr_s = cand_s + SEL_WIDTH'(1'b1);

    // Candidate selection. The round-robin scan starts at ptr_r, and the
    // index wraps naturally at SEL_WIDTH bits.
    always_comb begin
        grant_s    = 1'b0;
        cand_s     = {SEL_WIDTH{1'b0}};
        scan_idx_s = {SEL_WIDTH{1'b0}};
        if (i_mode) begin
            for (int j = 0; j < N; j++) begin
                scan_idx_s = ptr_r + SEL_WIDTH'(j);
                if (!grant_s && i_valid[scan_idx_s]) begin
                    grant_s = 1'b1;
                    cand_s  = scan_idx_s;
                end else begin
                    grant_s = grant_s;
                end
            end
        end else begin
            cand_s  = i_sel;
            grant_s = i_valid[i_sel];
        end
    end

    // One-hot acknowledge to the granted channel. It is forced low while reset is held.
    always_comb begin
        o_ready_in = {N{1'b0}};
        if (load_s && grant_s && !reset) begin
            o_ready_in[cand_s] = 1'b1;
        end else begin
            o_ready_in = {N{1'b0}};
        end
    end

    // Output register and round-robin pointer. Only round-robin grants move the pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            ch_r    <= {SEL_WIDTH{1'b0}};
            ptr_r   <= {SEL_WIDTH{1'b0}};
        end else if (load_s) begin
            if (grant_s) begin
                data_r  <= ch_data_s[cand_s];
                ch_r    <= cand_s;
                valid_r <= 1'b1;
                if (i_mode) begin
                    ptr_r <= next_ptr_s;
                end
            end else begin
                valid_r <= 1'b0;
            end
        end
    end

    assign o       = data_r;
    assign o_valid = valid_r;
    assign o_ch    = ch_r;
endmodule

// File: tb/tb_stream_mux_arb.sv
// Testbench for stream_mux_arb. It combines directed scenarios with
// randomized traffic. A reference model predicts o_ready_in and o_valid
// every cycle and pushes each granted word into a scoreboard queue. A
// separate monitor compares the output register against the queue front.
module tb_stream_mux_arb;
    localparam int SW = 2;
    localparam int W  = 8;
    localparam int N  = 4;

    logic           clk;
    logic           reset;
    logic [N*W-1:0] i;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   o_ready_in;
    logic [SW-1:0]  i_sel;
    logic           i_mode;
    logic [W-1:0]   o;
    logic           o_valid;
    logic           i_ready;
    logic [SW-1:0]  o_ch;

    stream_mux_arb #(.SEL_WIDTH(SW), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .i(i), .i_valid(i_valid), .o_ready_in(o_ready_in),
        .i_sel(i_sel), .i_mode(i_mode), .o(o), .o_valid(o_valid), .i_ready(i_ready), .o_ch(o_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] d; logic [SW-1:0] ch; } word_t;
    word_t q[$];

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;   // model round-robin pointer
    bit m_ov  = 0;   // model output-register occupancy

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: while the output holds a word, it must match the queue front.
    // The front is popped when the downstream side accepts the word.
    always @(negedge clk) begin
        if (!reset && o_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_word", 32'(o_valid), 32'd0);
            end else begin
                chk("o_data", 32'(o), 32'(q[0].d));
                chk("o_ch", 32'(o_ch), 32'(q[0].ch));
                if (i_ready) void'(q.pop_front());
            end
        end
    end

    // Apply one cycle of stimulus. At mid-cycle, predict and check the
    // handshake, then update the model across the coming edge.
    task automatic step(input logic [N-1:0] v, input logic [SW-1:0] s, input logic m,
                        input logic r, input logic [N*W-1:0] d);
        bit load, found;
        int k;
        logic [N-1:0] exp_rdy;
        i_valid = v; i_sel = s; i_mode = m; i_ready = r; i = d;
        @(negedge clk);
        chk("o_valid", 32'(o_valid), 32'(m_ov));
        load = !m_ov || r;
        found = 0; k = 0;
        if (m) begin
            for (int off = 0; off < N; off++) begin
                if (!found && v[(m_ptr + off) % N]) begin
                    found = 1; k = (m_ptr + off) % N;
                end
            end
        end else begin
            k = int'(s); found = v[k];
        end
        exp_rdy = (load && found) ? N'(1 << k) : '0;
        chk("o_ready_in", 32'(o_ready_in), 32'(exp_rdy));
        if (load) begin
            m_ov = found;
            if (found) begin
                word_t w;
                w.d = d[k*W +: W]; w.ch = SW'(k);
                q.push_back(w);
                if (m) m_ptr = (k + 1) % N;
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom} & {(N*W){1'b1}};
    endfunction

    initial begin
        logic [N*W-1:0] d;
        reset = 1'b1; i = '0; i_valid = 4'b1111; i_sel = 2'd0; i_mode = 1'b1; i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o", 32'(o), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_ch", 32'(o_ch), 32'd0);
        chk("rst_ready", 32'(o_ready_in), 32'd0);
        reset = 1'b0;

        // Fixed mode: channel 2 is selected.
        d = '0; d[2*W +: W] = 8'hA5;
        step(4'b0100, 2'd2, 1'b0, 1'b1, d);
        // Fixed mode with the selected channel idle.
        step(4'b1101, 2'd1, 1'b0, 1'b1, rnd_data());
        step(4'b1101, 2'd1, 1'b0, 1'b1, rnd_data());

        // Round-robin with all four channels valid.
        for (int c = 0; c < 8; c++) step(4'b1111, 2'd0, 1'b1, 1'b1, rnd_data());
        // Set the pointer to 1, then wrap from channel 3 to channel 0.
        step(4'b0001, 2'd0, 1'b1, 1'b1, rnd_data());
        step(4'b1001, 2'd0, 1'b1, 1'b1, rnd_data());
        step(4'b1001, 2'd0, 1'b1, 1'b1, rnd_data());
        step(4'b1111, 2'd0, 1'b1, 1'b1, rnd_data());

        // Backpressure: hold 8'h11 for three cycles while ch1 waits.
        d = rnd_data(); d[0 +: W] = 8'h11;
        step(4'b0001, 2'd0, 1'b0, 1'b1, d);
        for (int c = 0; c < 3; c++) step(4'b0010, 2'd1, 1'b0, 1'b0, rnd_data());
        step(4'b0010, 2'd1, 1'b0, 1'b1, rnd_data());

        // Reset between edges while a word is held.
        step(4'b0100, 2'd0, 1'b1, 1'b0, rnd_data());
        i_valid = 4'b1111;
        #2 reset = 1'b1;
        #1;
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_o", 32'(o), 32'd0);
        chk("midrst_o_ch", 32'(o_ch), 32'd0);
        chk("midrst_ready", 32'(o_ready_in), 32'd0);
        q.delete(); m_ov = 0; m_ptr = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        step(4'b1111, 2'd3, 1'b1, 1'b1, rnd_data());
        step(4'b1111, 2'd3, 1'b1, 1'b1, rnd_data());

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            step(N'($urandom), SW'($urandom), 1'($urandom), ($urandom_range(3, 0) != 0), rnd_data());
        end

        // Drain, with a bounded number of cycles.
        for (int c = 0; c < 10; c++) step(4'b0000, 2'd0, 1'b1, 1'b1, rnd_data());
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
